mem_read_throttle: RTL and testbench

Sits between the core memory arbiter and the shared memory port. Tracks outstanding read bursts per 2-bit memory ID and stalls new reads for an ID that has reached its outstanding limit. Counts returning read beats to retire each burst. Writes pass through unthrottled, and the block reports per-ID busy status and protocol errors.

---
 rtl/mem_read_throttle_if.sv | 18 +
 rtl/mem_read_throttle.sv | 141 ++++++++++++++
 tb/tb_mem_read_throttle.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_throttle_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_read_throttle_if: request/ack bundle between arbiter and memory   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface mem_read_throttle_if;
  logic        request;
  logic [29:0] addr;
  logic [4:0]  rlen;
  logic        rnw;
  logic        rmw;
  logic [1:0]  id;
  logic        ack;

  modport master (output request, addr, rlen, rnw, rmw, id, input ack);
  modport slave  (input request, addr, rlen, rnw, rmw, id, output ack);
endinterface
`default_nettype wire

// File: rtl/mem_read_throttle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_read_throttle: per-ID outstanding read burst limiter              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_read_throttle #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_read_throttle_if.slave         up,
  mem_read_throttle_if.master        mem,
  input  logic                       mem_rvalid,
  input  logic [1:0]                 mem_rid,
  output logic [3:0]                 id_busy,
  output logic [3:0]                 id_full,
  output logic                       idle,
  output logic                       unexpected_rvalid
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] C_FULL     = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [CW-1:0] count_q [4];
  logic [CW-1:0] count_d [4];
  logic [4:0]    beat_q  [4];
  logic [4:0]    beat_d  [4];
  logic [PW-1:0] wptr_q  [4];
  logic [PW-1:0] wptr_d  [4];
  logic [PW-1:0] rptr_q  [4];
  logic [PW-1:0] rptr_d  [4];
  logic [4:0]    fifo_q  [4][MAX_OUTSTANDING];
  logic [4:0]    fifo_d  [4][MAX_OUTSTANDING];
  logic [3:0]    busy_q, busy_d;
  logic [3:0]    full_q, full_d;
  logic          idle_q, idle_d;
  logic          unexp_q, unexp_d;

  logic          w_is_read;
  logic          w_block;
  logic          w_accept;
  logic          w_beat_ok;
  logic          w_complete;
  logic [3:0]    w_push;
  logic [3:0]    w_pop;
  logic [3:0]    w_beat_hit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Block decision uses registered counts only; a completion this cycle does not unblock.
  assign w_is_read  = up.rnw | up.rmw;
  assign w_block    = w_is_read & (count_q[up.id] == C_FULL);
  assign mem.request = up.request & ~w_block;
  assign mem.addr   = up.addr;
  assign mem.rlen   = up.rlen;
  assign mem.rnw    = up.rnw;
  assign mem.rmw    = up.rmw;
  assign mem.id     = up.id;
  assign up.ack     = mem.request & mem.ack;

  assign w_accept   = up.ack & w_is_read;
  assign w_beat_ok  = mem_rvalid & (count_q[mem_rid] != '0);
  assign w_complete = w_beat_ok & (beat_q[mem_rid] == fifo_q[mem_rid][rptr_q[mem_rid]]);

  for (genvar i = 0; i < 4; i++) begin : g_id
    assign w_push[i]     = w_accept   & (up.id   == 2'(i));
    assign w_pop[i]      = w_complete & (mem_rid == 2'(i));
    assign w_beat_hit[i] = w_beat_ok  & (mem_rid == 2'(i));
  end

  always_comb begin
    count_d = count_q;
    beat_d  = beat_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fifo_d  = fifo_q;
    busy_d  = '0;
    full_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_push[i]) begin
        fifo_d[i][wptr_q[i]] = up.rlen;
        wptr_d[i]            = next_ptr(wptr_q[i]);
      end
      if (w_pop[i]) begin
        rptr_d[i] = next_ptr(rptr_q[i]);
        beat_d[i] = '0;
      end else if (w_beat_hit[i]) begin
        beat_d[i] = beat_q[i] + 5'd1;
      end
      case ({w_push[i], w_pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
      busy_d[i] = (count_d[i] != '0);
      full_d[i] = (count_d[i] == C_FULL);
    end
    idle_d  = ~|busy_d;
    unexp_d = mem_rvalid & (count_q[mem_rid] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        count_q[i] <= '0;
        beat_q[i]  <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
      end
      busy_q  <= '0;
      full_q  <= '0;
      idle_q  <= 1'b1;
      unexp_q <= 1'b0;
    end else begin
      count_q <= count_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      idle_q  <= idle_d;
      unexp_q <= unexp_d;
    end
  end

  // Storage needs no reset: entries are only read while their count is non-zero.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign id_busy           = busy_q;
  assign id_full           = full_q;
  assign idle              = idle_q;
  assign unexpected_rvalid = unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_throttle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_read_throttle: directed + random bench with queue-based model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_read_throttle;
  localparam int MAX = 4;

  logic       clk;
  logic       rst;
  logic       mem_rvalid;
  logic [1:0] mem_rid;
  logic [3:0] id_busy;
  logic [3:0] id_full;
  logic       idle;
  logic       unexpected_rvalid;

  mem_read_throttle_if up_if ();
  mem_read_throttle_if mem_if ();

  mem_read_throttle #(.MAX_OUTSTANDING(MAX)) dut (
    .clk               (clk),
    .rst               (rst),
    .up                (up_if),
    .mem               (mem_if),
    .mem_rvalid        (mem_rvalid),
    .mem_rid           (mem_rid),
    .id_busy           (id_busy),
    .id_full           (id_full),
    .idle              (idle),
    .unexpected_rvalid (unexpected_rvalid)
  );

  int  n_checks;
  int  n_errors;
  bit  started;

  // Model: per ID, a queue of pending burst lengths and beats seen for the head burst.
  int  m_q     [4][$];
  int  m_beats [4];
  bit  m_unexp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rd, blk, acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_q[i].delete();
        m_beats[i] = 0;
      end
      m_unexp = 1'b0;
    end else begin
      rd  = up_if.rnw | up_if.rmw;
      blk = rd && (m_q[up_if.id].size() == MAX);
      acc = up_if.request && !blk && mem_if.ack && rd;
      m_unexp = 1'b0;
      if (mem_rvalid) begin
        if (m_q[mem_rid].size() == 0) begin
          m_unexp = 1'b1;
        end else begin
          m_beats[mem_rid]++;
          if (m_beats[mem_rid] == m_q[mem_rid][0] + 1) begin
            void'(m_q[mem_rid].pop_front());
            m_beats[mem_rid] = 0;
          end
        end
      end
      if (acc) m_q[up_if.id].push_back(int'(up_if.rlen));
    end
  endtask

  always @(negedge clk) begin
    bit rd, blk, exp_req;
    if (started) begin
      rd      = up_if.rnw | up_if.rmw;
      blk     = rd && (m_q[up_if.id].size() == MAX);
      exp_req = up_if.request && !blk;
      check("mem_request", mem_if.request, exp_req);
      check("up_ack", up_if.ack, exp_req && mem_if.ack);
      check("fields", {mem_if.addr, mem_if.rlen, mem_if.rnw, mem_if.rmw, mem_if.id},
                      {up_if.addr, up_if.rlen, up_if.rnw, up_if.rmw, up_if.id});
      for (int i = 0; i < 4; i++) begin
        check("id_busy", id_busy[i], m_q[i].size() != 0);
        check("id_full", id_full[i], m_q[i].size() == MAX);
      end
      check("idle", idle, (m_q[0].size() + m_q[1].size() + m_q[2].size() + m_q[3].size()) == 0);
      check("unexpected_rvalid", unexpected_rvalid, m_unexp);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    up_if.request = 1'b0;
    up_if.addr    = 30'($urandom());
    up_if.rlen    = '0;
    up_if.rnw     = 1'b0;
    up_if.rmw     = 1'b0;
    up_if.id      = '0;
    mem_if.ack    = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rid       = '0;
  endtask

  task automatic rd(input logic [1:0] id, input logic [4:0] len);
    up_if.request = 1'b1;
    up_if.rnw     = 1'b1;
    up_if.rmw     = 1'b0;
    up_if.id      = id;
    up_if.rlen    = len;
    mem_if.ack    = 1'b1;
  endtask

  task automatic beat(input logic [1:0] id);
    mem_rvalid = 1'b1;
    mem_rid    = id;
  endtask

  initial begin
    logic wack;
    n_checks = 0;
    n_errors = 0;
    started  = 1'b0;
    m_unexp  = 1'b0;
    for (int i = 0; i < 4; i++) m_beats[i] = 0;
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    #1;
    check("rst_idle", idle, 1'b1);
    check("rst_busy", id_busy, 4'b0000);
    check("rst_full", id_full, 4'b0000);
    check("rst_unexp", unexpected_rvalid, 1'b0);

    // Single read, id 1, four beats
    clr(); rd(2'd1, 5'd3); #1;
    check("single_ack", up_if.ack, 1'b1);
    tick();
    clr(); #1;
    check("single_busy_c1", id_busy, 4'b0010);
    tick();
    for (int k = 0; k < 4; k++) begin
      clr(); beat(2'd1); #1;
      if (k == 3) check("single_busy_c5", id_busy, 4'b0010);
      tick();
    end
    clr(); #1;
    check("single_busy_c6", id_busy, 4'b0000);
    check("single_idle_c6", idle, 1'b1);
    tick();

    // Limit on id 2
    for (int k = 0; k < 4; k++) begin
      clr(); rd(2'd2, 5'd0); tick();
    end
    clr(); rd(2'd2, 5'd0); #1;
    check("limit_req", mem_if.request, 1'b0);
    check("limit_ack", up_if.ack, 1'b0);
    check("limit_full", id_full, 4'b0100);
    beat(2'd2);
    tick();
    clr(); rd(2'd2, 5'd0); #1;
    check("limit_unblock_ack", up_if.ack, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      clr(); beat(2'd2); tick();
    end
    clr(); #1;
    check("limit_drain_idle", idle, 1'b1);
    tick();

    // Same-cycle accept and completion on id 0
    clr(); rd(2'd0, 5'd0); tick();
    clr(); rd(2'd0, 5'd7); tick();
    clr(); rd(2'd0, 5'd2); beat(2'd0); #1;
    check("same_ack", up_if.ack, 1'b1);
    tick();
    for (int k = 0; k < 11; k++) begin
      clr(); beat(2'd0); #1;
      if (k == 7 || k == 8) check("same_busy", id_busy, 4'b0001);
      tick();
    end
    clr(); #1;
    check("same_idle", idle, 1'b1);
    tick();

    // Writes pass on a full id 3
    for (int k = 0; k < 4; k++) begin
      clr(); rd(2'd3, 5'd0); tick();
    end
    for (int w = 0; w < 10; w++) begin
      clr();
      up_if.request = 1'b1;
      up_if.id      = 2'd3;
      wack          = 1'($urandom_range(0, 1));
      mem_if.ack    = wack;
      #1;
      check("wr_req", mem_if.request, 1'b1);
      check("wr_ack", up_if.ack, wack);
      tick();
    end
    clr();
    up_if.request = 1'b1;
    up_if.rmw     = 1'b1;
    up_if.id      = 2'd3;
    mem_if.ack    = 1'b1;
    #1;
    check("rmw_blocked", mem_if.request, 1'b0);
    check("wr_full", id_full, 4'b1000);
    tick();
    for (int k = 0; k < 4; k++) begin
      clr(); beat(2'd3); tick();
    end

    // Stray beat
    clr(); beat(2'd2); tick();
    clr(); #1;
    check("stray_pulse", unexpected_rvalid, 1'b1);
    check("stray_idle", idle, 1'b1);
    tick();
    clr(); #1;
    check("stray_pulse_end", unexpected_rvalid, 1'b0);
    tick();

    // Reset mid-operation
    clr(); rd(2'd0, 5'd3); tick();
    clr(); rd(2'd1, 5'd3); tick();
    clr(); rd(2'd0, 5'd3); tick();
    clr(); #1;
    check("pre_rst_busy", id_busy, 4'b0011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr(); #1;
    check("post_rst_idle", idle, 1'b1);
    check("post_rst_busy", id_busy, 4'b0000);
    beat(2'd0);
    tick();
    clr(); #1;
    check("post_rst_unexp", unexpected_rvalid, 1'b1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clr();
      rst           = ($urandom_range(0, 499) == 0);
      up_if.request = ($urandom_range(0, 3) != 0);
      up_if.rnw     = ($urandom_range(0, 3) != 0);
      up_if.rmw     = ($urandom_range(0, 7) == 0);
      up_if.id      = 2'($urandom());
      up_if.rlen    = ($urandom_range(0, 7) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 2));
      mem_if.ack    = ($urandom_range(0, 3) != 0);
      mem_rvalid    = 1'($urandom_range(0, 1));
      mem_rid       = 2'($urandom());
      tick();
    end
    rst = 1'b0;
    clr();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
